// File: rtl/roic_lane_align_ctrl.sv
// Multi-lane bit-alignment controller: rotates each deserialised lane word and
// either searches every lane for the training patterns in turn or applies a manual shift.
module roic_lane_align_ctrl #(
  parameter int                    NUM_LANES     = 4,
  parameter int                    DATA_WIDTH    = 24,
  parameter logic [DATA_WIDTH-1:0] PATTERN_1     = 24'hFFF000,
  parameter logic [DATA_WIDTH-1:0] PATTERN_2     = 24'hFF0000,
  parameter int                    MATCH_COUNT   = 4,
  parameter int                    SETTLE_CYCLES = 8,
  localparam int                   SHIFT_W       = $clog2(DATA_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   din,
  input  logic                              din_valid,
  input  logic                              align_to_fclk,
  input  logic                              align_start,
  input  logic [SHIFT_W-1:0]                extra_shift,
  output logic [NUM_LANES*DATA_WIDTH-1:0]   dout,
  output logic                              dout_valid,
  output logic [NUM_LANES*SHIFT_W-1:0]      shift_out,
  output logic [NUM_LANES-1:0]              lane_locked,
  output logic                              align_busy,
  output logic                              align_done,
  output logic                              align_fail
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int MC_W  = $clog2(MATCH_COUNT + 1);

  localparam logic [SHIFT_W-1:0] MAX_SHIFT   = SHIFT_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]   LAST_LANE   = IDX_W'(NUM_LANES - 1);
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [MC_W-1:0]    MATCH_LAST  = MC_W'(MATCH_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_ADVANCE,
    S_DONE,
    S_FAIL
  } state_e;

  state_e                             state_q;
  logic [NUM_LANES-1:0][SHIFT_W-1:0]  shift_q;
  logic [NUM_LANES*DATA_WIDTH-1:0]    prev_q;
  logic [NUM_LANES*DATA_WIDTH-1:0]    dout_q;
  logic [NUM_LANES*DATA_WIDTH-1:0]    dout_d;
  logic                               dout_valid_q;
  logic [NUM_LANES-1:0]               lane_locked_q;
  logic                               busy_q;
  logic                               done_q;
  logic                               fail_q;
  logic                               start_q;
  logic [IDX_W-1:0]                   idx_q;
  logic [SHIFT_W-1:0]                 cand_q;
  logic [SET_W-1:0]                   settle_cnt_q;
  logic [MC_W-1:0]                    match_cnt_q;

  logic                               start_rise;
  logic                               cur_match;
  logic [SHIFT_W-1:0]                 manual_shift;
  logic [DATA_WIDTH-1:0]              cur_word;

  // Window of {current, previous} word selected by each lane's shift.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [2*DATA_WIDTH-1:0] cat;
    assign cat = {din[gi*DATA_WIDTH +: DATA_WIDTH], prev_q[gi*DATA_WIDTH +: DATA_WIDTH]};
    assign dout_d[gi*DATA_WIDTH +: DATA_WIDTH] = cat[shift_q[gi] +: DATA_WIDTH];
  end

  always_comb begin
    manual_shift = (extra_shift > MAX_SHIFT) ? MAX_SHIFT : extra_shift;
    start_rise   = align_start & ~start_q;
    cur_word     = dout_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    cur_match    = (cur_word == PATTERN_1) || (cur_word == PATTERN_2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= din_valid;
      if (din_valid) begin
        prev_q <= din;
        dout_q <= dout_d;
      end
    end
  end

  // Sequencer: one lane at a time, candidate shift driven live onto that lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      lane_locked_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      start_q       <= 1'b0;
      idx_q         <= '0;
      cand_q        <= '0;
      settle_cnt_q  <= '0;
      match_cnt_q   <= '0;
    end else begin
      start_q <= align_start;
      if (align_to_fclk) begin
        state_q       <= S_IDLE;
        lane_locked_q <= '0;
        busy_q        <= 1'b0;
        done_q        <= 1'b1;
        fail_q        <= 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
          shift_q[l] <= manual_shift;
        end
      end else begin
        case (state_q)
          S_IDLE, S_DONE, S_FAIL: begin
            if (start_rise) begin
              state_q       <= S_SETTLE;
              idx_q         <= '0;
              cand_q        <= '0;
              shift_q[0]    <= '0;
              settle_cnt_q  <= '0;
              lane_locked_q <= '0;
              busy_q        <= 1'b1;
              done_q        <= 1'b0;
              fail_q        <= 1'b0;
            end else if (state_q == S_IDLE) begin
              done_q <= 1'b0;
            end
          end

          S_SETTLE: begin
            if (dout_valid_q) begin
              if (settle_cnt_q == SETTLE_LAST) begin
                state_q      <= S_CHECK;
                settle_cnt_q <= '0;
                match_cnt_q  <= '0;
              end else begin
                settle_cnt_q <= settle_cnt_q + 1'b1;
              end
            end
          end

          S_CHECK: begin
            if (dout_valid_q) begin
              if (cur_match) begin
                if (match_cnt_q == MATCH_LAST) begin
                  lane_locked_q[idx_q] <= 1'b1;
                  state_q              <= S_ADVANCE;
                end else begin
                  match_cnt_q <= match_cnt_q + 1'b1;
                end
              end else if (cand_q < MAX_SHIFT) begin
                cand_q         <= cand_q + 1'b1;
                shift_q[idx_q] <= cand_q + 1'b1;
                settle_cnt_q   <= '0;
                state_q        <= S_SETTLE;
              end else begin
                // Exhausted every rotation: park the lane at zero, unlocked.
                shift_q[idx_q] <= '0;
                state_q        <= S_ADVANCE;
              end
            end
          end

          S_ADVANCE: begin
            if (idx_q == LAST_LANE) begin
              busy_q <= 1'b0;
              if (&lane_locked_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_FAIL;
                fail_q  <= 1'b1;
              end
            end else begin
              idx_q                   <= idx_q + 1'b1;
              cand_q                  <= '0;
              shift_q[idx_q + 1'b1]   <= '0;
              settle_cnt_q            <= '0;
              state_q                 <= S_SETTLE;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign shift_out   = shift_q;
  assign lane_locked = lane_locked_q;
  assign align_busy  = busy_q;
  assign align_done  = done_q;
  assign align_fail  = fail_q;

endmodule
